// File: rtl/run_gen_pkg.sv
// Shared definitions for the run-length pattern generator and its detector predictor.
package run_gen_pkg;

   localparam int LEN_W_DEF  = 4;
   localparam int STREAK_MAX = 3;

   typedef enum logic {
      RG_IDLE = 1'b0,
      RG_RUN  = 1'b1
   } rg_state_e;

endpackage

// File: rtl/run_streak_tracker.sv
// Predicts the 000/111 run detector output for the stream leaving run_pattern_gen.
// Only instantiated when RUN_PATTERN_GEN_PRED_EN is defined.
module run_streak_tracker
   import run_gen_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic x,
   input  logic x_valid,
   output logic exp_y
);

   logic [1:0] streak_q, streak_d;
   logic       last_q, last_d;

   // Idle cycles leave the streak untouched, so gaps are invisible to the detector model.
   always_comb begin
      streak_d = streak_q;
      last_d   = last_q;
      if (x_valid) begin
         last_d = x;
         if (streak_q != 2'd0 && x == last_q)
            streak_d = (streak_q == 2'(STREAK_MAX)) ? streak_q : streak_q + 2'd1;
         else
            streak_d = 2'd1;
      end
      exp_y = x_valid && (streak_d >= 2'(STREAK_MAX));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak_q <= 2'd0;
         last_q   <= 1'b0;
      end else begin
         streak_q <= streak_d;
         last_q   <= last_d;
      end
   end

endmodule

// File: rtl/run_pattern_gen.sv
// Serial run-length transmitter: (bit, length) commands in, 1-bit stream x out.
// Define RUN_PATTERN_GEN_PRED_EN to drive exp_y from the detector predictor.
module run_pattern_gen
   import run_gen_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_bit,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             exp_y
);

   rg_state_e        state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             load;

   // cnt_q counts the bits still to send including the one on x now, so 1 marks the last bit.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      x_d       = x_q;
      x_valid_d = x_valid_q;
      cmd_ready = (state_q == RG_IDLE) || (cnt_q == LEN_W'(1));
      load      = cmd_valid && cmd_ready && (cmd_len != '0);

      if (load) begin
         state_d   = RG_RUN;
         cnt_d     = cmd_len;
         x_d       = cmd_bit;
         x_valid_d = 1'b1;
      end else if (state_q == RG_RUN) begin
         if (cnt_q == LEN_W'(1)) begin
            state_d   = RG_IDLE;
            cnt_d     = '0;
            x_valid_d = 1'b0;
         end else begin
            cnt_d = cnt_q - LEN_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RG_IDLE;
         cnt_q     <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
      end
   end

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign busy    = (state_q == RG_RUN);

`ifdef RUN_PATTERN_GEN_PRED_EN
   run_streak_tracker u_streak (
      .clk     (clk),
      .rst_n   (rst_n),
      .x       (x_q),
      .x_valid (x_valid_q),
      .exp_y   (exp_y)
   );
`else
   assign exp_y = 1'b0;
`endif

endmodule

// File: tb/tb_run_pattern_gen.sv
// Directed bench for run_pattern_gen: per-cycle vector table plus multi-cycle corner sequences.
module tb_run_pattern_gen;

`ifdef RUN_PATTERN_GEN_PRED_EN
   localparam bit PRED = 1'b1;
`else
   localparam bit PRED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_bit;
   logic [3:0] cmd_len;
   logic       x;
   logic       x_valid;
   logic       busy;
   logic       exp_y;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic       v;
      logic       b;
      logic [3:0] l;
      logic       rdy;
      logic       x;
      logic       xv;
      logic       busy;
      logic       y;    // detector prediction when the predictor is built
   } vec_t;

   vec_t vecs[20];

   run_pattern_gen #(.LEN_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_bit   (cmd_bit),
      .cmd_len   (cmd_len),
      .x         (x),
      .x_valid   (x_valid),
      .busy      (busy),
      .exp_y     (exp_y)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic rdy, input logic ex, input logic xv,
                             input logic bz, input logic y);
      check({tag, " cmd_ready"}, cmd_ready, rdy);
      check({tag, " x"},         x,         ex);
      check({tag, " x_valid"},   x_valid,   xv);
      check({tag, " busy"},      busy,      bz);
      check({tag, " exp_y"},     exp_y,     y & PRED);
   endtask

   task automatic drive(input logic v, input logic b, input logic [3:0] l);
      cmd_valid = v;
      cmd_bit   = b;
      cmd_len   = l;
   endtask

   initial begin
      // Each row: inputs held for that cycle, outputs expected during that cycle.
      //            v  b  l   rdy x  xv bsy y
      vecs[0]  = '{1, 1, 3,  1, 0, 0, 0, 0};   // (1,3) accepted
      vecs[1]  = '{0, 0, 0,  0, 1, 1, 1, 0};
      vecs[2]  = '{0, 0, 0,  0, 1, 1, 1, 0};
      vecs[3]  = '{0, 0, 0,  1, 1, 1, 1, 1};   // last bit, third 1
      vecs[4]  = '{0, 0, 0,  1, 1, 0, 0, 0};   // idle, x holds 1
      vecs[5]  = '{1, 0, 0,  1, 1, 0, 0, 0};   // len=0 consumed
      vecs[6]  = '{0, 0, 0,  1, 1, 0, 0, 0};
      vecs[7]  = '{1, 0, 2,  1, 1, 0, 0, 0};   // (0,2) accepted
      vecs[8]  = '{1, 0, 2,  0, 0, 1, 1, 0};   // second (0,2) held, ignored
      vecs[9]  = '{1, 0, 2,  1, 0, 1, 1, 0};   // accepted back-to-back
      vecs[10] = '{0, 0, 0,  0, 0, 1, 1, 1};
      vecs[11] = '{0, 0, 0,  1, 0, 1, 1, 1};
      vecs[12] = '{0, 0, 0,  1, 0, 0, 0, 0};
      vecs[13] = '{1, 1, 2,  1, 0, 0, 0, 0};   // (1,2)
      vecs[14] = '{1, 0, 2,  0, 1, 1, 1, 0};
      vecs[15] = '{1, 0, 2,  1, 1, 1, 1, 0};   // (0,2)
      vecs[16] = '{1, 1, 1,  0, 0, 1, 1, 0};
      vecs[17] = '{1, 1, 1,  1, 0, 1, 1, 0};   // (1,1)
      vecs[18] = '{0, 0, 0,  1, 1, 1, 1, 0};
      vecs[19] = '{0, 0, 0,  1, 1, 0, 0, 0};

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 4'd0);
      repeat (2) @(negedge clk);
      check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].v, vecs[i].b, vecs[i].l);
         check_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].x, vecs[i].xv,
                    vecs[i].busy, vecs[i].y);
         @(negedge clk);
      end

      // Maximum length run of zeros: exactly 15 valid cycles, no wrap.
      drive(1'b1, 1'b0, 4'd15);
      check_outs("max accept", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0);
      for (int k = 0; k < 15; k++) begin
         check_outs($sformatf("max bit%0d", k), (k == 14), 1'b0, 1'b1, 1'b1, (k >= 2));
         @(negedge clk);
      end
      check_outs("max idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset during the second bit of a (1,5) run.
      drive(1'b1, 1'b1, 4'd5);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0);
      check_outs("rst bit0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check_outs("rst bit1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 4'd3);
      rst_n = 1'b0;
      #1;
      check_outs("rst async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_outs("rst held", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_outs("rst no capture", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'd3);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0);
      for (int k = 0; k < 3; k++) begin
         check_outs($sformatf("post bit%0d", k), (k == 2), 1'b0, 1'b1, 1'b1, (k == 2));
         @(negedge clk);
      end
      check_outs("post idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/run_pattern_gen.md
Name: run_pattern_gen

Overview:
- Serial run-length pattern transmitter: accepts (bit, length) commands over a valid/ready handshake and drives a 1-bit serial stream x.
- Each command produces exactly `length` consecutive cycles of the commanded bit.
- Sits upstream of the 000/111 run detector as its stimulus/transmit end.
- Optionally emits the expected detector output for self-checking.

Parameters:
- LEN_W, 4, width of the run-length field; maximum run = 2**LEN_W-1 cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command this cycle
- cmd_bit  input  1  bit value of the run
- cmd_len  input  LEN_W  run length in cycles; 0 = no-op
- x  output  1  serial data out, registered
- x_valid  output  1  x carries a run bit this cycle, registered
- busy  output  1  state == RUN
- exp_y  output  1  predicted detector output (see Optional Feature)

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: x=0, x_valid=0, busy=0, exp_y=0. State=IDLE, cnt=0, streak=0. cmd_ready=1 once in IDLE.
- Command accept: the handshake completes on the rising edge where cmd_valid && cmd_ready.
- FSM has two states, IDLE and RUN:
  - IDLE: cmd_ready=1. On accept with cmd_len!=0, go to RUN and load cnt=cmd_len; on the next cycle x=cmd_bit, x_valid=1. On accept with cmd_len==0, consume the command and stay in IDLE with no output.
  - RUN: x_valid=1 and x=run bit. cnt decrements every cycle. cmd_ready=1 only when cnt==1 (last bit of the run).
    - If cnt==1 and a command with len!=0 is accepted: reload cnt and bit, stay in RUN. This gives back-to-back runs with no gap.
    - If cnt==1 and a command with len==0 is accepted, or no command arrives: go to IDLE.
- Latency: first bit appears 1 cycle after the accepting edge. A run of L produces exactly L x_valid cycles.
- Idle: x holds the last driven bit; x_valid=0.
- cmd_* inputs are ignored when cmd_ready=0. The source must hold them stable until accepted.
- cnt width is LEN_W. It never wraps, because it is reloaded or the FSM leaves RUN at 1.
- Reset mid-run: the run is abandoned immediately. All outputs and state return to reset values asynchronously. The pending command is not captured.

Optional Feature:
- Macro: RUN_PATTERN_GEN_PRED_EN.
- Defined:
  - A streak counter (saturating at 3, 2 bits) advances only on x_valid cycles.
  - If the new bit equals the last valid bit, streak = min(streak+1, 3); otherwise streak = 1.
  - Streak continues across back-to-back runs and across idle gaps (gaps are transparent to the model).
  - exp_y = x_valid && (streak including the current bit) >= 3, aligned with x.
  - This matches the overlapping detection of 000/111.
- Not defined: exp_y tied to 0 and no streak logic is synthesized.

Decomposition:
- Shared package run_gen_pkg:
  - state encoding constants RG_IDLE=0, RG_RUN=1
  - default LEN_W
  - STREAK_MAX=3
- Sub-module run_streak_tracker (inputs clk, rst_n, x, x_valid; output exp_y) holds the predictor. It is instantiated only under RUN_PATTERN_GEN_PRED_EN.

Test Plan:
- Reset then cmd (bit=1, len=3) accepted at edge N -> x=1, x_valid=1 for cycles N+1..N+3. Then x_valid=0, x stays 1, and exp_y=1 only at N+3 (macro on).
- Back-to-back: (0,2) then (0,2) held valid -> 4 contiguous x_valid cycles of 0. cmd_ready=1 only on the last cycle of each run. exp_y=1 on the 3rd and 4th bits.
- len=0 command in IDLE -> accepted and consumed in one cycle; x_valid stays 0; busy stays 0.
- Max length (bit=0, len=15 with LEN_W=4) -> exactly 15 valid cycles, no wrap. exp_y=1 from the 3rd bit onward.
- Alternating runs (1,2), (0,2), (1,1) -> stream 1,1,0,0,1 and exp_y stays 0 throughout.
- Assert rst_n low on the 2nd bit of a (1,5) run -> x, x_valid, busy and exp_y go to 0 immediately. After release, cmd_ready=1 and a new (0,3) run plays normally with a fresh streak.
